// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: state encoding,
// the halt instruction word and default memory geometry.
package if_fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_t;

   localparam logic [31:0] HALT_WORD      = 32'hFFFF_FFFF;
   localparam int          DEFAULT_ADDR_W = 5;
   localparam int          DEFAULT_DATA_W = 32;

endpackage

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the imem port, boots from a loader, then
// streams instructions to decode. Define IF_HALT_EN to stop on the halt word.
module if_fetch_ctrl
   import if_fetch_ctrl_pkg::*;
#(
   parameter int          ADDR_W   = DEFAULT_ADDR_W,
   parameter int          DATA_W   = DEFAULT_DATA_W,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_done,
   output logic              ld_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   output logic              halted
);

   localparam logic [ADDR_W-1:0] PC_START = ADDR_W'(RESET_PC);

   fetch_state_t      state;
   logic [ADDR_W-1:0] pc;

   // The loader drives the memory port directly while booting so every cycle can write.
   always_comb begin
      ld_ready  = (state == ST_BOOT);
      mem_we    = 1'b0;
      mem_addr  = pc;
      mem_wdata = '0;
      if (state == ST_BOOT) begin
         mem_we    = ld_valid & rst_n;
         mem_addr  = ld_addr;
         mem_wdata = ld_data;
      end
   end

`ifdef IF_HALT_EN
   assign halted = (state == ST_HALT);
`else
   assign halted = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_BOOT;
         pc          <= PC_START;
         instr       <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
      end else begin
         case (state)
            ST_BOOT: begin
               instr_valid <= 1'b0;
               if (ld_done) begin
                  state <= ST_RUN;
                  pc    <= PC_START;
               end
            end
            ST_RUN: begin
               // Redirect beats stall and squashes the word fetched this cycle.
               if (redirect) begin
                  pc          <= redirect_pc;
                  instr_valid <= 1'b0;
               end else if (!stall) begin
`ifdef IF_HALT_EN
                  if (mem_rdata == DATA_W'(HALT_WORD)) begin
                     state       <= ST_HALT;
                     instr_valid <= 1'b0;
                  end else begin
                     instr       <= mem_rdata;
                     instr_pc    <= pc;
                     instr_valid <= 1'b1;
                     pc          <= pc + ADDR_W'(1);
                  end
`else
                  instr       <= mem_rdata;
                  instr_pc    <= pc;
                  instr_valid <= 1'b1;
                  pc          <= pc + ADDR_W'(1);
`endif
               end
            end
            ST_HALT: begin
               instr_valid <= 1'b0;
            end
            default: begin
               state       <= ST_BOOT;
               instr_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
